// File: rtl/expmul_unit.sv
// expmul_unit: online-softmax exponent-multiply stage; scales v* and o* by rounded
// powers of two via barrel shifts, one register stage with valid/ready handshake.
module expmul_unit #(
    parameter int DIM       = 65,
    parameter int DATA_W    = 27,
    parameter int DIFF_W    = 9,
    parameter int DIFF_FRAC = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  vld_in,
    output logic                  rdy_out,
    output logic                  vld_out,
    input  logic                  rdy_in,
    input  logic [DIFF_W-1:0]     m_in,
    input  logic [DIFF_W-1:0]     m_prev_in,
    input  logic [DIFF_W-1:0]     s_in,
    input  logic [DIM*DATA_W-1:0] o_star_prev_in,
    input  logic [DIM*DATA_W-1:0] v_star_in,
    output logic [DIM*DATA_W-1:0] exp_v_out,
    output logic [DIM*DATA_W-1:0] exp_o_out
);
    localparam int TW = DIFF_W + 6;
    localparam int KW = 7;
    localparam int VW = DIM * DATA_W;
    localparam int XW = DATA_W + 47;

    // log2(e) ~= 23/16, so 23*d carries DIFF_FRAC+4 fractional bits before rounding
    function automatic logic signed [KW-1:0] kexp(input logic [DIFF_W-1:0] a, input logic [DIFF_W-1:0] b);
        logic signed [DIFF_W:0] d;
        logic signed [TW-1:0] t;
        d = {a[DIFF_W-1], a} - {b[DIFF_W-1], b};
        t = TW'(d) * TW'(23) + TW'(1 << (DIFF_FRAC + 3));
        t = t >>> (DIFF_FRAC + 4);
        return t[KW-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] x, input logic signed [KW-1:0] k);
        logic [5:0] n;
        logic [XW-1:0] w;
        logic signed [DATA_W-1:0] xs;
        logic [DATA_W-1:0] r;
        xs = x;
        n = k[KW-1] ? 6'(-k) : 6'(k);
        w = {{(XW-DATA_W){x[DATA_W-1]}}, x} << n;
        if (k[KW-1])
            r = xs >>> n;
        else if (w[XW-1:DATA_W-1] == {(XW-DATA_W+1){w[XW-1]}})
            r = w[DATA_W-1:0];
        else
            r = {w[XW-1], {(DATA_W-1){~w[XW-1]}}};
        return r;
    endfunction

    logic signed [KW-1:0] kv, ko;
    logic [VW-1:0] ev_d, eo_d, ev_q, eo_q;
    logic vld_q;

    assign kv = kexp(s_in, m_in);
    assign ko = kexp(m_prev_in, m_in);

    for (genvar i = 0; i < DIM; i++) begin : g_el
        assign ev_d[i*DATA_W +: DATA_W] = scale(v_star_in[i*DATA_W +: DATA_W], kv);
        assign eo_d[i*DATA_W +: DATA_W] = scale(o_star_prev_in[i*DATA_W +: DATA_W], ko);
    end

    assign rdy_out   = !vld_q || rdy_in;
    assign vld_out   = vld_q;
    assign exp_v_out = ev_q;
    assign exp_o_out = eo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            ev_q  <= '0;
            eo_q  <= '0;
        end else begin
            if (rdy_out) vld_q <= vld_in;
            if (vld_in && rdy_out) begin
                ev_q <= ev_d;
                eo_q <= eo_d;
            end
        end
    end
endmodule

// File: tb/tb_expmul_unit.sv
// tb_expmul_unit: directed, handshake and randomized checks against an arithmetic model.
module tb_expmul_unit;
    localparam int DIM = 65;
    localparam int W   = 27;
    localparam int VW  = DIM * W;
    localparam longint SMAX = 67108863;
    localparam longint SMIN = -67108864;

    logic clk = 1'b0;
    logic rst, vld_in, rdy_in, rdy_out, vld_out;
    logic [8:0] m_in, m_prev_in, s_in;
    logic [VW-1:0] o_star_prev_in, v_star_in, exp_v_out, exp_o_out;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    expmul_unit dut (
        .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out), .vld_out(vld_out),
        .rdy_in(rdy_in), .m_in(m_in), .m_prev_in(m_prev_in), .s_in(s_in),
        .o_star_prev_in(o_star_prev_in), .v_star_in(v_star_in),
        .exp_v_out(exp_v_out), .exp_o_out(exp_o_out)
    );

    // k = floor(23*d/256 + 1/2) with d in units of 1/16
    function automatic int kexp(int a, int b);
        int num, q;
        num = 23 * (a - b) + 128;
        q = num / 256;
        if (num < 0 && num % 256 != 0) q--;
        return q;
    endfunction

    // x * 2^k: floor division for k<0, clamped product for k>0
    function automatic longint scl(longint x, int k);
        longint p, q;
        if (k < 0) begin
            p = longint'(1) << (-k);
            q = x / p;
            if (x < 0 && x % p != 0) q--;
            return q;
        end
        if (k >= W) return x > 0 ? SMAX : (x < 0 ? SMIN : 0);
        q = x * (longint'(1) << k);
        return q > SMAX ? SMAX : (q < SMIN ? SMIN : q);
    endfunction

    function automatic logic [VW-1:0] model(logic [VW-1:0] vec, int k);
        logic [VW-1:0] r;
        for (int i = 0; i < DIM; i++)
            r[i*W +: W] = W'(scl(longint'($signed(vec[i*W +: W])), k));
        return r;
    endfunction

    function automatic int el(logic [VW-1:0] vec, int i);
        return int'($signed(vec[i*W +: W]));
    endfunction

    function automatic int fd(logic [VW-1:0] a, logic [VW-1:0] b);
        for (int i = 0; i < DIM; i++)
            if (a[i*W +: W] !== b[i*W +: W]) return i;
        return -1;
    endfunction

    function automatic logic [VW-1:0] rvec();
        logic [VW-1:0] r;
        for (int i = 0; i < DIM; i++) r[i*W +: W] = W'($urandom);
        return r;
    endfunction

    task automatic apply(int s, int m, int mp, logic [VW-1:0] v, logic [VW-1:0] o);
        s_in = 9'(s);
        m_in = 9'(m);
        m_prev_in = 9'(mp);
        v_star_in = v;
        o_star_prev_in = o;
        vld_in = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vld_in = 1'b1;
        rdy_in = 1'b1;
        apply(0, 0, 0, rvec(), rvec());
        tick();
        tick();
        vld_in = 1'b0;
        rst = 1'b0;
        #1;
        total++;
        if (vld_out !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", vld_out); end
        total++;
        if (exp_v_out !== '0 || exp_o_out !== '0) begin
            bad++;
            $display("FAIL reset_data: v el%0d=%0d o el%0d=%0d want 0",
                     fd(exp_v_out, '0), el(exp_v_out, 0), fd(exp_o_out, '0), el(exp_o_out, 0));
        end
        total++;
        if (rdy_out !== 1'b1) begin bad++; $display("FAIL reset_rdy: got %b want 1", rdy_out); end
    endtask

    typedef struct {int s; int m; int mp; int idx; int vv; int ov; int ev; int eo;} dcase_t;

    task automatic test_directed();
        dcase_t t[6];
        logic [VW-1:0] v, o, ev, eo;
        t = '{'{-16, 0, 0, 1, 40, 7, 20, 7},
              '{0, 0, 0, 0, 131072, -5, 131072, -5},
              '{-128, 0, 0, 1, 131072, 3, 64, 3},
              '{0, 0, 128, 1, 9, 50, 9, 204800},
              '{-256, -256, 255, 0, 131072, 131072, 131072, 67108863},
              '{-256, 255, 255, 1, 50, -50, 0, -50}};
        rdy_in = 1'b1;
        for (int c = 0; c < 6; c++) begin
            v = rvec();
            o = rvec();
            v[t[c].idx*W +: W] = W'(t[c].vv);
            o[t[c].idx*W +: W] = W'(t[c].ov);
            ev = model(v, kexp(t[c].s, t[c].m));
            eo = model(o, kexp(t[c].mp, t[c].m));
            apply(t[c].s, t[c].m, t[c].mp, v, o);
            tick();
            vld_in = 1'b0;
            total++;
            if (vld_out !== 1'b1) begin bad++; $display("FAIL dir%0d_vld: got %b want 1", c, vld_out); end
            total++;
            if (el(exp_v_out, t[c].idx) !== t[c].ev) begin
                bad++;
                $display("FAIL dir%0d_v: got %0d want %0d", c, el(exp_v_out, t[c].idx), t[c].ev);
            end
            total++;
            if (el(exp_o_out, t[c].idx) !== t[c].eo) begin
                bad++;
                $display("FAIL dir%0d_o: got %0d want %0d", c, el(exp_o_out, t[c].idx), t[c].eo);
            end
            total++;
            if (exp_v_out !== ev || exp_o_out !== eo) begin
                bad++;
                $display("FAIL dir%0d_vec: v diff el%0d o diff el%0d", c, fd(exp_v_out, ev), fd(exp_o_out, eo));
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] va, oa, vb, ob, vc, oc;
        va = rvec(); oa = rvec(); vb = rvec(); ob = rvec(); vc = rvec(); oc = rvec();
        rdy_in = 1'b0;
        apply(-40, 10, 30, va, oa);
        tick();
        total++;
        if (vld_out !== 1'b1 || rdy_out !== 1'b0) begin
            bad++;
            $display("FAIL bp_stall: vld=%b rdy=%b want 1 0", vld_out, rdy_out);
        end
        apply(-100, -20, 60, vb, ob);
        tick();
        tick();
        tick();
        total++;
        if (exp_v_out !== model(va, kexp(-40, 10)) || exp_o_out !== model(oa, kexp(30, 10)) || vld_out !== 1'b1) begin
            bad++;
            $display("FAIL bp_hold: vld=%b v diff el%0d want held A", vld_out, fd(exp_v_out, model(va, kexp(-40, 10))));
        end
        rdy_in = 1'b1;
        #1;
        total++;
        if (rdy_out !== 1'b1) begin bad++; $display("FAIL bp_rdy: got %b want 1", rdy_out); end
        tick();
        total++;
        if (exp_v_out !== model(vb, kexp(-100, -20)) || exp_o_out !== model(ob, kexp(60, -20)) || vld_out !== 1'b1) begin
            bad++;
            $display("FAIL b2b_B: vld=%b v diff el%0d", vld_out, fd(exp_v_out, model(vb, kexp(-100, -20))));
        end
        apply(5, 7, 200, vc, oc);
        tick();
        total++;
        if (exp_v_out !== model(vc, kexp(5, 7)) || exp_o_out !== model(oc, kexp(200, 7)) || vld_out !== 1'b1) begin
            bad++;
            $display("FAIL b2b_C: vld=%b v diff el%0d", vld_out, fd(exp_v_out, model(vc, kexp(5, 7))));
        end
        vld_in = 1'b0;
        tick();
        total++;
        if (vld_out !== 1'b0 || exp_v_out !== model(vc, kexp(5, 7))) begin
            bad++;
            $display("FAIL drain_keep: vld=%b v diff el%0d want vld 0 data C", vld_out, fd(exp_v_out, model(vc, kexp(5, 7))));
        end
    endtask

    task automatic test_reset_mid();
        rdy_in = 1'b0;
        apply(-3, 0, 9, rvec(), rvec());
        tick();
        vld_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rdy_in = 1'b1;
        total++;
        if (vld_out !== 1'b0 || exp_v_out !== '0 || exp_o_out !== '0) begin
            bad++;
            $display("FAIL reset_mid: vld=%b v el0=%0d o el0=%0d want 0", vld_out, el(exp_v_out, 0), el(exp_o_out, 0));
        end
    endtask

    task automatic test_random();
        int a[3];
        int tmp;
        logic [VW-1:0] v, o, ev, eo;
        rdy_in = 1'b1;
        for (int n = 0; n < 512; n++) begin
            for (int j = 0; j < 3; j++) a[j] = int'($urandom_range(0, 511)) - 256;
            if (a[0] > a[1]) begin tmp = a[0]; a[0] = a[1]; a[1] = tmp; end
            if (a[1] > a[2]) begin tmp = a[1]; a[1] = a[2]; a[2] = tmp; end
            if (a[0] > a[1]) begin tmp = a[0]; a[0] = a[1]; a[1] = tmp; end
            v = rvec();
            o = rvec();
            ev = model(v, kexp(a[0], a[1]));
            eo = model(o, kexp(a[2], a[1]));
            apply(a[0], a[1], a[2], v, o);
            tick();
            total++;
            if (vld_out !== 1'b1 || exp_v_out !== ev || exp_o_out !== eo) begin
                bad++;
                $display("FAIL rand%0d: vld=%b s=%0d m=%0d mp=%0d v diff el%0d o diff el%0d",
                         n, vld_out, a[0], a[1], a[2], fd(exp_v_out, ev), fd(exp_o_out, eo));
            end
        end
        vld_in = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
